// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the game display.
//
// Walks a horizontal pixel counter (h_cnt) and a vertical line counter
// (v_cnt) across the full raster, one position per enabled clk_tmp edge, and
// produces registered sync, active-video, coordinate and strobe outputs.
// The outputs are decodes of the counter position *before* each enabled edge,
// so they trail the counters by exactly one enabled cycle.
//
// en is a plain qualifier, not a handshake: on a rising edge with en=1 the
// raster advances one pixel and the outputs reload; with en=0 the counters
// and level outputs hold and the two strobes drop to 0.
//
// Ports:
//   clk_tmp      in   pixel clock (divided clock)
//   rst          in   asynchronous, active-high reset
//   en           in   pixel advance enable
//   hsync        out  horizontal sync, active level = SYNC_POL
//   vsync        out  vertical sync, active level = SYNC_POL
//   video_on     out  output pixel lies in the visible area
//   pix_x        out  column of the output pixel (0 outside visible area)
//   pix_y        out  row of the output pixel (0 outside visible area)
//   line_start   out  one-cycle strobe for the output pixel at h=0
//   frame_start  out  one-cycle strobe for the output pixel at h=0, v=0
//   frame_cnt    out  completed-frame count, wraps modulo 2^FW; it steps on
//                     the edge where the counters wrap from the last pixel
//                     of the frame back to (0,0)
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CW       = 10,
  parameter int FW       = 16
) (
  input  logic          clk_tmp,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Range limits are held one bit wider than the counters so that a sync
  // pulse ending exactly at the total (zero back porch) still compares
  // correctly even when the total equals 2^CW.
  localparam int CE = CW + 1;
  localparam logic [CE-1:0] H_VIS    = CE'(H_ACTIVE);
  localparam logic [CE-1:0] HS_START = CE'(H_ACTIVE + H_FP);
  localparam logic [CE-1:0] HS_END   = CE'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CE-1:0] V_VIS    = CE'(V_ACTIVE);
  localparam logic [CE-1:0] VS_START = CE'(V_ACTIVE + V_FP);
  localparam logic [CE-1:0] VS_END   = CE'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;

  logic [CE-1:0] h_ext;
  logic [CE-1:0] v_ext;
  logic          hs_act;
  logic          vs_act;
  logic          vis_act;
  logic          h_last;
  logic          v_last;

  always_comb begin
    h_ext   = {1'b0, h_cnt};
    v_ext   = {1'b0, v_cnt};
    hs_act  = (h_ext >= HS_START) && (h_ext < HS_END);
    // vsync decodes v_cnt only, so it naturally changes with the first
    // pixel of a line.
    vs_act  = (v_ext >= VS_START) && (v_ext < VS_END);
    vis_act = (h_ext < H_VIS) && (v_ext < V_VIS);
    h_last  = (h_cnt == H_LAST);
    v_last  = (v_cnt == V_LAST);
  end

  always_ff @(posedge clk_tmp or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      video_on    <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      // Output stage: decode of the position held before this edge.
      hsync       <= hs_act ? SYNC_ON : SYNC_OFF;
      vsync       <= vs_act ? SYNC_ON : SYNC_OFF;
      video_on    <= vis_act;
      pix_x       <= vis_act ? h_cnt : '0;
      pix_y       <= vis_act ? v_cnt : '0;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);

      // Raster advance; horizontal and vertical wraps resolve in one edge.
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + FW'(1);
        end else begin
          v_cnt <= v_cnt + CW'(1);
        end
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end else begin
      // Stalled: everything holds except the strobes, which must never
      // repeat for the same pixel.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen.
//
// Two instances share clk_tmp/rst/en: one with the default 640x480 geometry
// and one with a tiny 7x5 raster so frame wrap and frame_cnt wrap are reached
// quickly. The reference model describes the output for a given number of
// enabled edges since reset using division and remainder on the raster size.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        von;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk_tmp = 1'b0;
  logic rst     = 1'b0;
  logic en      = 1'b1;

  always #5 clk_tmp = ~clk_tmp;

  // ---------------- DUTs ----------------
  logic       d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
  logic [9:0] d_pix_x, d_pix_y;
  logic [15:0] d_frame_cnt;

  logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [9:0] s_pix_x, s_pix_y;
  logic [1:0] s_frame_cnt;

  vga_timing_gen u_dut_def (
    .clk_tmp    (clk_tmp),
    .rst        (rst),
    .en         (en),
    .hsync      (d_hsync),
    .vsync      (d_vsync),
    .video_on   (d_video_on),
    .pix_x      (d_pix_x),
    .pix_y      (d_pix_y),
    .line_start (d_line_start),
    .frame_start(d_frame_start),
    .frame_cnt  (d_frame_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FW(2)
  ) u_dut_small (
    .clk_tmp    (clk_tmp),
    .rst        (rst),
    .en         (en),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .video_on   (s_video_on),
    .pix_x      (s_pix_x),
    .pix_y      (s_pix_y),
    .line_start (s_line_start),
    .frame_start(s_frame_start),
    .frame_cnt  (s_frame_cnt)
  );

  // ---------------- reference model ----------------
  // t_m  : enabled, non-reset edges since the last reset
  // le_m : the most recent edge was enabled and out of reset
  longint t_m  = 0;
  bit     le_m = 1'b0;

  always @(posedge clk_tmp) begin
    if (rst) begin
      t_m  <= 0;
      le_m <= 1'b0;
    end else begin
      if (en) t_m <= t_m + 1;
      le_m <= en;
    end
  end

  // Output after t enabled edges: the pixel shown is raster position t-1,
  // and frame_cnt counts how many full rasters the counters have completed.
  function automatic obs_t model(input longint ha, hfp, hsw, hbp,
                                 input longint va, vfp, vsw, vbp,
                                 input longint fw, input longint t,
                                 input bit le);
    obs_t   o;
    longint ht, vt, p, h, v, f;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (t == 0) return o;
    ht   = ha + hfp + hsw + hbp;
    vt   = va + vfp + vsw + vbp;
    p    = t - 1;
    h    = p % ht;
    v    = (p / ht) % vt;
    f    = (t / (ht * vt)) % (64'd1 << fw);
    o.hs = !(h >= ha + hfp && h < ha + hfp + hsw);
    o.vs = !(v >= va + vfp && v < va + vfp + vsw);
    o.von = (h < ha) && (v < va);
    o.px = o.von ? 10'(h) : 10'd0;
    o.py = o.von ? 10'(v) : 10'd0;
    o.ls = le && (h == 0);
    o.fs = le && (h == 0) && (v == 0);
    o.fc = 16'(f);
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  always @(negedge clk_tmp) begin
    obs_t de, da, se, sa;
    de = model(640, 16, 96, 48, 480, 10, 2, 33, 16, t_m, le_m);
    se = model(4, 1, 1, 1, 2, 1, 1, 1, 2, t_m, le_m);
    da = {d_hsync, d_vsync, d_video_on, d_pix_x, d_pix_y,
          d_line_start, d_frame_start, d_frame_cnt};
    sa = {s_hsync, s_vsync, s_video_on, s_pix_x, s_pix_y,
          s_line_start, s_frame_start, 14'd0, s_frame_cnt};
    n_tests++;
    if (da !== de) begin
      n_fail++;
      $display("FAIL cycle_def t=%0d actual=%h expected=%h", t_m, da, de);
    end
    n_tests++;
    if (sa !== se) begin
      n_fail++;
      $display("FAIL cycle_small t=%0d actual=%h expected=%h", t_m, sa, se);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Drive en for one edge and return at the following negedge.
  task automatic step(input logic e);
    en = e;
    @(posedge clk_tmp);
    @(negedge clk_tmp);
  endtask

  task automatic run_to(input longint target);
    int guard = 0;
    while (t_m < target && guard < 5000) begin
      step(1'b1);
      guard++;
    end
    chk("run_to", t_m, target);
  endtask

  // ---------------- stimulus ----------------
  longint ls_prev;
  int     ls_pairs;

  initial begin
    #1 rst = 1'b1;
    @(negedge clk_tmp);
    repeat (3) step(1'b1);

    // Reset values with the clock running and en=1.
    chk("rst_hsync",     d_hsync, 1);
    chk("rst_vsync",     d_vsync, 1);
    chk("rst_video_on",  d_video_on, 0);
    chk("rst_pix_x",     d_pix_x, 0);
    chk("rst_pix_y",     d_pix_y, 0);
    chk("rst_frame_cnt", d_frame_cnt, 0);

    rst = 1'b0;
    step(1'b1);
    chk("first_frame_start", d_frame_start, 1);
    chk("first_line_start",  d_line_start, 1);
    chk("first_video_on",    d_video_on, 1);
    chk("first_pix_x",       d_pix_x, 0);

    // Small raster: 7 pixels x 5 lines = 35 cycles per frame.
    run_to(6);   chk("s_hsync_h5",        s_hsync, 0);
    run_to(7);   chk("s_hsync_h6",        s_hsync, 1);
    run_to(21);  chk("s_vsync_line2_end", s_vsync, 1);
    run_to(22);  chk("s_vsync_line3",     s_vsync, 0);
    run_to(29);  chk("s_vsync_line4",     s_vsync, 1);
    run_to(35);  chk("s_fcnt_at_wrap",    s_frame_cnt, 1);
                 chk("s_fstart_before",   s_frame_start, 0);
    run_to(36);  chk("s_fstart_frame1",   s_frame_start, 1);
    run_to(71);  chk("s_fstart_frame2",   s_frame_start, 1);
                 chk("s_fcnt_frame2",     s_frame_cnt, 2);
    run_to(141); chk("s_fcnt_wrap",       s_frame_cnt, 0);

    // Default raster horizontal landmarks.
    run_to(640); chk("d_last_pix_x",     d_pix_x, 639);
                 chk("d_last_video_on",  d_video_on, 1);
    run_to(641); chk("d_blank_video_on", d_video_on, 0);
                 chk("d_blank_pix_x",    d_pix_x, 0);
    run_to(656); chk("d_hsync_h655",     d_hsync, 1);
    run_to(657); chk("d_hsync_h656",     d_hsync, 0);
    run_to(752); chk("d_hsync_h751",     d_hsync, 0);
    run_to(753); chk("d_hsync_h752",     d_hsync, 1);
    run_to(801); chk("d_line1_start",    d_line_start, 1);
                 chk("d_line1_pix_y",    d_pix_y, 1);
                 chk("d_line1_fstart",   d_frame_start, 0);

    // en toggling: line_start spacing doubles to 1600 clock cycles.
    ls_prev  = -1;
    ls_pairs = 0;
    for (int c = 0; c < 3400; c++) begin
      step(c[0] == 1'b0 ? 1'b0 : 1'b1);
      if (d_line_start) begin
        if (ls_prev >= 0) begin
          chk("toggle_line_gap", c - ls_prev, 1600);
          ls_pairs++;
        end
        ls_prev = c;
      end
    end
    chk("toggle_gap_seen", (ls_pairs > 0) ? 1 : 0, 1);

    // Reset mid-line: takes effect before the next clock edge.
    run_to(t_m + 437);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_hsync",     d_hsync, 1);
    chk("mid_rst_video_on",  d_video_on, 0);
    chk("mid_rst_pix_x",     d_pix_x, 0);
    chk("mid_rst_line",      d_line_start, 0);
    chk("mid_rst_s_fcnt",    s_frame_cnt, 0);
    @(negedge clk_tmp);
    repeat (3) step(1'b1);
    rst = 1'b0;
    step(1'b1);
    chk("mid_rel_fstart",    d_frame_start, 1);
    chk("mid_rel_pix_x",     d_pix_x, 0);
    chk("mid_rel_d_fcnt",    d_frame_cnt, 0);
    chk("mid_rel_s_fcnt",    s_frame_cnt, 0);
    run_to(34);  chk("mid_s_fcnt_hold", s_frame_cnt, 0);
    run_to(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the game display, clocked by the divided clock `clk_tmp`.
- Produces hsync/vsync, active-video flag, pixel coordinates and frame/line strobes.
- Feeds the sprite/playfield renderer and the game-logic frame tick.
- Default geometry is 640x480@60 at a 25 MHz pixel rate; all timing comes from parameters.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CW, 10, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FW, 16, frame counter width

Ports:
- clk_tmp  in  1  pixel clock (divided clock)
- rst  in  1  reset; asynchronous, active-high
- en  in  1  pixel advance enable; counters step only when 1
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- video_on  out  1  high while the output pixel is inside the active area
- pix_x  out  CW  column of the output pixel; 0 outside the active area
- pix_y  out  CW  row of the output pixel; 0 outside the active area
- line_start  out  1  one-cycle strobe at h=0 of every line
- frame_start  out  1  one-cycle strobe at h=0, v=0
- frame_cnt  out  FW  completed-frame count; wraps modulo 2^FW

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Internal counters: h_cnt counts 0..H_TOTAL-1; v_cnt counts 0..V_TOTAL-1.
- Counter update on each clk_tmp rising edge with en=1:
  - h_cnt increments.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 together with h_cnt = H_TOTAL-1, v_cnt wraps to 0 and frame_cnt increments, wrapping modulo 2^FW.
- en=0: counters, frame_cnt, hsync, vsync, video_on, pix_x and pix_y hold; line_start and frame_start are forced to 0.
- Output stage: all outputs are registered decodes of the counter state before the edge. Latency is 1 enabled cycle, so outputs at edge k reflect counters at edge k-1.
- Decodes (sync "asserted" means driven to the SYNC_POL level):
  - hsync asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (default 490..491). vsync changes aligned to h_cnt = 0.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - pix_x = h_cnt and pix_y = v_cnt when video_on, else 0.
  - line_start = (h_cnt == 0). frame_start = (h_cnt == 0 && v_cnt == 0).
- Reset values (asynchronous; take effect immediately on rst assertion):
  - h_cnt = 0, v_cnt = 0, frame_cnt = 0.
  - hsync = vsync = ~SYNC_POL (deasserted).
  - video_on = 0, pix_x = pix_y = 0, line_start = frame_start = 0.
- After release: first enabled edge outputs (0,0) with video_on=1, line_start=1, frame_start=1.
- Reset mid-frame: all outputs return to reset values at once; the timing restarts from (0,0) with no partial-frame frame_cnt increment.
- Simultaneous horizontal and vertical wrap is handled in the same edge; no skipped or duplicated line.

Test Plan:
- Reset check: assert rst with clk_tmp running, en=1 -> hsync=1, vsync=1, video_on=0, pix_x=0, pix_y=0, frame_cnt=0. Release -> first edge gives frame_start=1, line_start=1, video_on=1, pix_x=0.
- Horizontal timing, defaults, en=1: consecutive line_start pulses 800 cycles apart; hsync low for exactly 96 cycles starting 656 cycles after line_start; video_on high 640 cycles per active line; pix_x ramps 0..639.
- Vertical/frame timing, defaults: frame_start pulses 420000 cycles apart; vsync low for 1600 cycles beginning at line 490; pix_y ends at 479; frame_cnt increments by 1 per frame.
- Enable gating: toggle en 1/0 each cycle -> every output period doubles (line_start 1600 cycles apart). Each strobe is high exactly one cycle, never during en=0. Held outputs are unchanged across en=0 cycles.
- Reset mid-operation: assert rst at line 300, pixel 400 for 3 cycles -> immediate reset values; after release the next frame_start arrives 1 edge later and frame_cnt stays 0.
- Small geometry with counter wrap: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, FW=2.
  - frame_start every 35 cycles.
  - frame_cnt sequence 0,1,2,3,0.
  - hsync asserted at h=5 only.
  - vsync asserted on line 3 only.
